// File: rtl/data_utlb_pkg.sv
// Shared types and address-decode helpers for the data micro-TLB.
// Also holds the FSM encoding, which the instruction-side uTLB uses as well.
package data_utlb_pkg;

    localparam int VPN_W = 20;

    typedef enum logic {
        UTLB_IDLE  = 1'b0,
        UTLB_QUERY = 1'b1
    } utlb_state_e;

    typedef struct packed {
        logic             valid;
        logic [VPN_W-1:0] vpn;
        logic [VPN_W-1:0] ppn;
        logic             miss;
        logic             invalid;
        logic             dirty;
        logic [2:0]       cattr;
    } utlb_entry_t;

    // kseg0/kseg1 occupy 0x8000_0000..0xBFFF_FFFF and are never translated
    function automatic logic is_kseg01(input logic [31:0] vaddr);
        return (vaddr[31:30] == 2'b10);
    endfunction

    function automatic logic kseg_cached(input logic [31:0] vaddr, input logic [2:0] k0);
        return (vaddr[29] == 1'b0) && k0[0];
    endfunction

    function automatic logic [31:0] kseg_paddr(input logic [31:0] vaddr);
        return {3'b000, vaddr[28:0]};
    endfunction

endpackage

// File: rtl/data_utlb_match.sv
// Combinational ENTRIES-way VPN comparator: one-hot hit vector, hit flag,
// encoded hit index and the lowest-numbered free (invalid) slot.
module data_utlb_match
    import data_utlb_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int PTR_W   = $clog2(ENTRIES)
) (
    input  logic [ENTRIES-1:0]       entry_valid_i,
    input  logic [ENTRIES*VPN_W-1:0] entry_vpn_i,
    input  logic [VPN_W-1:0]         lk_vpn_i,
    output logic [ENTRIES-1:0]       hit_vec_o,
    output logic                     hit_o,
    output logic [PTR_W-1:0]         hit_idx_o,
    output logic                     free_o,
    output logic [PTR_W-1:0]         free_idx_o
);

    logic [ENTRIES-1:0] hit_vec_s;
    logic [PTR_W-1:0]   hit_idx_s;
    logic               free_s;
    logic [PTR_W-1:0]   free_idx_s;

    // Scan from the top so the lowest matching/free index is the one kept
    always_comb begin
        hit_vec_s  = '0;
        hit_idx_s  = '0;
        free_s     = 1'b0;
        free_idx_s = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (entry_valid_i[i] && (entry_vpn_i[i*VPN_W +: VPN_W] == lk_vpn_i)) begin
                hit_vec_s[i] = 1'b1;
                hit_idx_s    = PTR_W'(i);
            end else begin
                hit_vec_s[i] = 1'b0;
            end
            if (!entry_valid_i[i]) begin
                free_s     = 1'b1;
                free_idx_s = PTR_W'(i);
            end else begin
                free_s     = free_s;
            end
        end
    end

    assign hit_vec_o  = hit_vec_s;
    assign hit_o      = |hit_vec_s;
    assign hit_idx_o  = hit_idx_s;
    assign free_o     = free_s;
    assign free_idx_o = free_idx_s;

endmodule

// File: rtl/data_utlb.sv
// Fully associative data micro-TLB with round-robin refill from the main TLB.
// Optional hit/miss counters are built when DATA_UTLB_PERF_EN is defined.
module data_utlb
    import data_utlb_pkg::*;
#(
    parameter  int ENTRIES = 4,
    localparam int PTR_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        lk_valid,
    input  logic [31:0] lk_vaddr,
    input  logic        lk_write,
    output logic        lk_ok,
    output logic [31:0] lk_paddr,
    output logic        lk_cached,
    output logic        lk_refill,
    output logic        lk_invalid,
    output logic        lk_mod,
    input  logic [2:0]  config_k0,
    output logic [31:0] tlb_vaddr,
    input  logic [31:0] tlb_paddr,
    input  logic        tlb_miss,
    input  logic        tlb_invalid,
    input  logic        tlb_dirty,
    input  logic [2:0]  tlb_cattr,
    input  logic        flush,
    output logic [31:0] perf_hit,
    output logic [31:0] perf_miss
);

    utlb_entry_t            entry_q [ENTRIES];
    utlb_state_e            state_q, state_d;
    logic [PTR_W-1:0]       rr_q, rr_d;
    logic [31:0]            tlb_vaddr_q, tlb_vaddr_d;

    logic [ENTRIES-1:0]       valid_vec_s;
    logic [ENTRIES*VPN_W-1:0] vpn_flat_s;
    logic [ENTRIES-1:0]       hit_vec_s;
    logic                     hit_s;
    logic [PTR_W-1:0]         hit_idx_s;
    logic                     free_s;
    logic [PTR_W-1:0]         free_idx_s;
    logic                     bypass_s;
    logic                     lk_ok_s;
    logic                     start_query_s;
    logic                     fill_s;
    logic [PTR_W-1:0]         victim_idx_s;
    utlb_entry_t              sel_entry_s;
    utlb_entry_t              new_entry_s;

    // Flatten entry tags for the comparator
    always_comb begin
        valid_vec_s = '0;
        vpn_flat_s  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            valid_vec_s[i]                  = entry_q[i].valid;
            vpn_flat_s[i*VPN_W +: VPN_W]    = entry_q[i].vpn;
        end
    end

    data_utlb_match #(
        .ENTRIES (ENTRIES),
        .PTR_W   (PTR_W)
    ) u_match (
        .entry_valid_i (valid_vec_s),
        .entry_vpn_i   (vpn_flat_s),
        .lk_vpn_i      (lk_vaddr[31:12]),
        .hit_vec_o     (hit_vec_s),
        .hit_o         (hit_s),
        .hit_idx_o     (hit_idx_s),
        .free_o        (free_s),
        .free_idx_o    (free_idx_s)
    );

    assign bypass_s    = is_kseg01(lk_vaddr);
    assign sel_entry_s = entry_q[hit_idx_s];
    assign lk_ok_s     = lk_valid && (state_q == UTLB_IDLE) && (bypass_s || hit_s);

    // Lookup result: cached miss/invalid results are reported like real hits
    always_comb begin
        lk_ok      = lk_ok_s;
        lk_paddr   = 32'd0;
        lk_cached  = 1'b0;
        lk_refill  = 1'b0;
        lk_invalid = 1'b0;
        lk_mod     = 1'b0;
        if (bypass_s) begin
            lk_paddr  = kseg_paddr(lk_vaddr);
            lk_cached = kseg_cached(lk_vaddr, config_k0);
        end else begin
            lk_paddr   = {sel_entry_s.ppn, lk_vaddr[11:0]};
            lk_cached  = sel_entry_s.cattr[0];
            lk_refill  = sel_entry_s.miss;
            lk_invalid = !sel_entry_s.miss && sel_entry_s.invalid;
            lk_mod     = lk_write && !sel_entry_s.miss && !sel_entry_s.invalid && !sel_entry_s.dirty;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= UTLB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            UTLB_IDLE: begin
                if (lk_valid && !bypass_s && !hit_s && !flush) begin
                    state_d = UTLB_QUERY;
                end else begin
                    state_d = UTLB_IDLE;
                end
            end
            UTLB_QUERY: state_d = UTLB_IDLE;
            default:    state_d = UTLB_IDLE;
        endcase
    end

    // FSM outputs: query launch and victim fill (a flush cancels the fill)
    always_comb begin
        start_query_s = 1'b0;
        fill_s        = 1'b0;
        case (state_q)
            UTLB_IDLE:  start_query_s = lk_valid && !bypass_s && !hit_s && !flush;
            UTLB_QUERY: fill_s        = !flush;
            default: begin
                start_query_s = 1'b0;
                fill_s        = 1'b0;
            end
        endcase
    end

    // Victim selection and round-robin advance (only when every slot is live)
    always_comb begin
        victim_idx_s = free_s ? free_idx_s : rr_q;
        if (fill_s && !free_s) begin
            rr_d = rr_q + PTR_W'(1);
        end else begin
            rr_d = rr_q;
        end
        if (start_query_s) begin
            tlb_vaddr_d = lk_vaddr;
        end else begin
            tlb_vaddr_d = tlb_vaddr_q;
        end
    end

    assign new_entry_s = '{
        valid:   1'b1,
        vpn:     tlb_vaddr_q[31:12],
        ppn:     tlb_paddr[31:12],
        miss:    tlb_miss,
        invalid: tlb_invalid,
        dirty:   tlb_dirty,
        cattr:   tlb_cattr
    };

    // Pointer and query-address registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_q        <= '0;
            tlb_vaddr_q <= 32'd0;
        end else begin
            rr_q        <= rr_d;
            tlb_vaddr_q <= tlb_vaddr_d;
        end
    end

    // Entry array: flush clears every valid bit and wins over a fill
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (flush) begin
                    entry_q[i].valid <= 1'b0;
                end else if (fill_s && (victim_idx_s == PTR_W'(i))) begin
                    entry_q[i] <= new_entry_s;
                end else begin
                    entry_q[i] <= entry_q[i];
                end
            end
        end
    end

    assign tlb_vaddr = tlb_vaddr_q;

`ifdef DATA_UTLB_PERF_EN
    logic [31:0] perf_hit_q, perf_hit_d;
    logic [31:0] perf_miss_q, perf_miss_d;

    // Counter increments: mapped hits only, one miss per query launch
    always_comb begin
        perf_hit_d  = perf_hit_q  + ((lk_ok_s && !bypass_s) ? 32'd1 : 32'd0);
        perf_miss_d = perf_miss_q + (start_query_s ? 32'd1 : 32'd0);
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_hit_q  <= 32'd0;
            perf_miss_q <= 32'd0;
        end else begin
            perf_hit_q  <= perf_hit_d;
            perf_miss_q <= perf_miss_d;
        end
    end

    assign perf_hit  = perf_hit_q;
    assign perf_miss = perf_miss_q;
`else
    assign perf_hit  = 32'd0;
    assign perf_miss = 32'd0;
`endif

    logic unused_ok_s;
    assign unused_ok_s = ^{tlb_paddr[11:0], config_k0[2:1], hit_vec_s,
                           sel_entry_s.valid, sel_entry_s.vpn, sel_entry_s.cattr[2:1]};

endmodule
